// File: rtl/wb_commit_pkg.sv
// Shared definitions for the writeback/commit stage: EFLAGS bit positions,
// operand-width encodings, reset constants and the FSM state type.
package wb_commit_pkg;

   localparam int EFLAGS_CF = 0;
   localparam int EFLAGS_PF = 2;
   localparam int EFLAGS_ZF = 6;
   localparam int EFLAGS_SF = 7;
   localparam int EFLAGS_OF = 11;

   localparam logic [1:0] WB_W8  = 2'b00;
   localparam logic [1:0] WB_W16 = 2'b01;
   localparam logic [1:0] WB_W32 = 2'b10;

   localparam logic [31:0] EFLAGS_RESET = 32'h0000_0002;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_WR1  = 1'b1
   } state_t;

   // mask/status are packed {CF,PF,ZF,SF,OF}, CF in the MSB
   function automatic logic [31:0] merge_flags(input logic [31:0] flags,
                                               input logic [4:0]  mask,
                                               input logic [4:0]  status);
      logic [31:0] r;
      r = flags;
      if (mask[4]) r[EFLAGS_CF] = status[4];
      if (mask[3]) r[EFLAGS_PF] = status[3];
      if (mask[2]) r[EFLAGS_ZF] = status[2];
      if (mask[1]) r[EFLAGS_SF] = status[1];
      if (mask[0]) r[EFLAGS_OF] = status[0];
      r[1] = 1'b1;
      return r;
   endfunction

endpackage

// File: rtl/wb_commit_align.sv
// Lane alignment for one register-file write: maps (idx, width, data) to the
// physical GPR index, lane-positioned data and byte enables.
module wb_align
   import wb_commit_pkg::*;
(
   input  logic [2:0]  idx,
   input  logic [1:0]  width,
   input  logic [31:0] data,
   output logic [2:0]  rf_idx,
   output logic [31:0] rf_data,
   output logic [3:0]  rf_be
);

   always_comb begin
      rf_idx  = idx;
      rf_data = data;
      rf_be   = 4'b1111;
      case (width)
         WB_W8: begin
            // encodings 4-7 are the high bytes AH/CH/DH/BH of regs 0-3
            if (idx[2]) begin
               rf_idx  = {1'b0, idx[1:0]};
               rf_data = {16'h0000, data[7:0], 8'h00};
               rf_be   = 4'b0010;
            end else begin
               rf_data = {24'h000000, data[7:0]};
               rf_be   = 4'b0001;
            end
         end
         WB_W16: begin
            rf_data = {16'h0000, data[15:0]};
            rf_be   = 4'b0011;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/wb_commit.sv
// Writeback/commit stage: drives the single register-file write port,
// serialises dual-destination instructions and owns architectural EFLAGS.
//
// state   | meaning
// --------+---------------------------------------------------------------
// ST_IDLE | ready; accepts one instruction and issues its first write
// ST_WR1  | second (wr1) write of a dual-destination instruction on rf_*
module wb_commit
   import wb_commit_pkg::*;
#(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ex_valid,
   output logic             ex_ready,
   input  logic             ex_wr0_en,
   input  logic [2:0]       ex_wr0_idx,
   input  logic [31:0]      ex_wr0_data,
   input  logic             ex_wr1_en,
   input  logic [2:0]       ex_wr1_idx,
   input  logic [31:0]      ex_wr1_data,
   input  logic [1:0]       ex_width,
   input  logic [4:0]       ex_flags_mask,
   input  logic [4:0]       ex_status,
   output logic             rf_we,
   output logic [2:0]       rf_idx,
   output logic [31:0]      rf_data,
   output logic [3:0]       rf_be,
   output logic [31:0]      eflags,
   output logic             retire,
   output logic [CNT_W-1:0] retire_cnt
);

   state_t      state, state_nxt;
   logic        accept;
   logic        wr_nxt, retire_nxt, lat_en, use_lat;
   logic [2:0]  lat_idx;
   logic [31:0] lat_data;
   logic [1:0]  lat_width;
   logic [2:0]  sel_idx, al_idx;
   logic [31:0] sel_data, al_data;
   logic [1:0]  sel_width;
   logic [3:0]  al_be;

   assign ex_ready = (state == ST_IDLE) && !rst;
   assign accept   = ex_valid && ex_ready;

   always_comb begin
      state_nxt  = state;
      wr_nxt     = 1'b0;
      retire_nxt = 1'b0;
      lat_en     = 1'b0;
      use_lat    = 1'b0;
      case (state)
         ST_IDLE: begin
            if (accept) begin
               wr_nxt = ex_wr0_en || ex_wr1_en;
               if (ex_wr0_en && ex_wr1_en) begin
                  lat_en    = 1'b1;
                  state_nxt = ST_WR1;
               end else begin
                  retire_nxt = 1'b1;
               end
            end
         end
         ST_WR1: begin
            wr_nxt     = 1'b1;
            retire_nxt = 1'b1;
            use_lat    = 1'b1;
            state_nxt  = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // One aligner serves both slots: the wr1 write is either taken straight
   // from execute (wr0 disabled) or replayed from the latch in ST_WR1.
   always_comb begin
      sel_idx   = ex_wr1_idx;
      sel_data  = ex_wr1_data;
      sel_width = ex_width;
      if (use_lat) begin
         sel_idx   = lat_idx;
         sel_data  = lat_data;
         sel_width = lat_width;
      end else if (ex_wr0_en) begin
         sel_idx   = ex_wr0_idx;
         sel_data  = ex_wr0_data;
      end
   end

   wb_align u_align (
      .idx     (sel_idx),
      .width   (sel_width),
      .data    (sel_data),
      .rf_idx  (al_idx),
      .rf_data (al_data),
      .rf_be   (al_be)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ST_IDLE;
         rf_we      <= 1'b0;
         rf_idx     <= 3'd0;
         rf_data    <= 32'd0;
         rf_be      <= 4'd0;
         retire     <= 1'b0;
         retire_cnt <= '0;
         eflags     <= EFLAGS_RESET;
         lat_idx    <= 3'd0;
         lat_data   <= 32'd0;
         lat_width  <= WB_W32;
      end else begin
         state   <= state_nxt;
         rf_we   <= wr_nxt;
         rf_idx  <= wr_nxt ? al_idx  : 3'd0;
         rf_data <= wr_nxt ? al_data : 32'd0;
         rf_be   <= wr_nxt ? al_be   : 4'd0;
         retire  <= retire_nxt;
         if (retire_nxt)
            retire_cnt <= retire_cnt + CNT_W'(1);
         if (accept)
            eflags <= merge_flags(eflags, ex_flags_mask, ex_status);
         if (lat_en) begin
            lat_idx   <= ex_wr1_idx;
            lat_data  <= ex_wr1_data;
            lat_width <= ex_width;
         end
      end
   end

endmodule

// File: tb/tb_wb_commit.sv
// Self-checking bench for wb_commit: directed scenarios with literal
// expectations plus randomized traffic compared against a queue-based model.
module tb_wb_commit;

   localparam int CNT_W = 4;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             ex_valid = 1'b0;
   logic             ex_ready;
   logic             ex_wr0_en = 1'b0;
   logic [2:0]       ex_wr0_idx = 3'd0;
   logic [31:0]      ex_wr0_data = 32'd0;
   logic             ex_wr1_en = 1'b0;
   logic [2:0]       ex_wr1_idx = 3'd0;
   logic [31:0]      ex_wr1_data = 32'd0;
   logic [1:0]       ex_width = 2'b10;
   logic [4:0]       ex_flags_mask = 5'd0;
   logic [4:0]       ex_status = 5'd0;
   logic             rf_we;
   logic [2:0]       rf_idx;
   logic [31:0]      rf_data;
   logic [3:0]       rf_be;
   logic [31:0]      eflags;
   logic             retire;
   logic [CNT_W-1:0] retire_cnt;

   wb_commit #(.CNT_W(CNT_W)) dut (
      .clk           (clk),
      .rst           (rst),
      .ex_valid      (ex_valid),
      .ex_ready      (ex_ready),
      .ex_wr0_en     (ex_wr0_en),
      .ex_wr0_idx    (ex_wr0_idx),
      .ex_wr0_data   (ex_wr0_data),
      .ex_wr1_en     (ex_wr1_en),
      .ex_wr1_idx    (ex_wr1_idx),
      .ex_wr1_data   (ex_wr1_data),
      .ex_width      (ex_width),
      .ex_flags_mask (ex_flags_mask),
      .ex_status     (ex_status),
      .rf_we         (rf_we),
      .rf_idx        (rf_idx),
      .rf_data       (rf_data),
      .rf_be         (rf_be),
      .eflags        (eflags),
      .retire        (retire),
      .retire_cnt    (retire_cnt)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   typedef struct {
      bit        we;
      bit [2:0]  idx;
      bit [31:0] data;
      bit [3:0]  be;
      bit        ret;
   } item_t;

   item_t     q[$];
   item_t     m_out;
   bit [31:0] m_ef = 32'h2;
   int        m_cnt = 0;
   bit        m_ready = 1'b1;
   bit        m_on = 1'b0;

   function automatic item_t mk_write(input bit [2:0] idx, input bit [31:0] d,
                                      input bit [1:0] w, input bit ret);
      item_t it;
      int    bits;
      bits = (w == 2'b00) ? 8 : (w == 2'b01) ? 16 : 32;
      it.we = 1'b1;
      it.ret = ret;
      it.idx = idx;
      if (bits == 32) begin
         it.be = 4'hF; it.data = d;
      end else if (bits == 16) begin
         it.be = 4'h3; it.data = d & 32'h0000FFFF;
      end else if (idx >= 4) begin
         it.idx = idx - 3'd4; it.be = 4'h2; it.data = (d & 32'hFF) << 8;
      end else begin
         it.be = 4'h1; it.data = d & 32'hFF;
      end
      return it;
   endfunction

   function automatic bit [31:0] model_flags(input bit [31:0] f, input bit [4:0] mask,
                                             input bit [4:0] st);
      int pos[5] = '{11, 7, 6, 2, 0};   // index = packed bit: OF,SF,ZF,PF,CF
      bit [31:0] r;
      r = f;
      for (int i = 0; i < 5; i++)
         if (mask[i]) r[pos[i]] = st[i];
      r[1] = 1'b1;
      return r;
   endfunction

   initial begin
      item_t idle_it;
      idle_it = '{we: 1'b0, idx: 3'd0, data: 32'd0, be: 4'd0, ret: 1'b0};
      m_out = idle_it;
      forever begin
         @(posedge clk);
         if (rst) begin
            q.delete();
            m_out   = idle_it;
            m_ef    = 32'h2;
            m_cnt   = 0;
            m_ready = 1'b1;
            m_on    = 1'b1;
         end else if (m_on) begin
            if (ex_valid && m_ready) begin
               m_ef = model_flags(m_ef, ex_flags_mask, ex_status);
               if (ex_wr0_en && ex_wr1_en) begin
                  q.push_back(mk_write(ex_wr0_idx, ex_wr0_data, ex_width, 1'b0));
                  q.push_back(mk_write(ex_wr1_idx, ex_wr1_data, ex_width, 1'b1));
               end else if (ex_wr0_en) begin
                  q.push_back(mk_write(ex_wr0_idx, ex_wr0_data, ex_width, 1'b1));
               end else if (ex_wr1_en) begin
                  q.push_back(mk_write(ex_wr1_idx, ex_wr1_data, ex_width, 1'b1));
               end else begin
                  item_t r;
                  r = idle_it;
                  r.ret = 1'b1;
                  q.push_back(r);
               end
            end
            m_out = (q.size() > 0) ? q.pop_front() : idle_it;
            if (m_out.ret) m_cnt = (m_cnt + 1) % (1 << CNT_W);
            m_ready = (q.size() == 0);
         end
      end
   end

   // per-cycle comparison against the model
   initial begin
      forever begin
         @(negedge clk);
         if (m_on) begin
            chk("ex_ready", 32'(ex_ready), 32'(!rst && m_ready));
            chk("rf_we", 32'(rf_we), 32'(m_out.we));
            if (m_out.we) begin
               chk("rf_idx", 32'(rf_idx), 32'(m_out.idx));
               chk("rf_data", rf_data, m_out.data);
               chk("rf_be", 32'(rf_be), 32'(m_out.be));
            end
            chk("retire", 32'(retire), 32'(m_out.ret));
            chk("retire_cnt", 32'(retire_cnt), 32'(m_cnt));
            chk("eflags", eflags, m_ef);
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic set_instr(input bit w0, input bit [2:0] i0, input bit [31:0] d0,
                            input bit w1, input bit [2:0] i1, input bit [31:0] d1,
                            input bit [1:0] w, input bit [4:0] m, input bit [4:0] s);
      ex_valid = 1'b1;
      ex_wr0_en = w0; ex_wr0_idx = i0; ex_wr0_data = d0;
      ex_wr1_en = w1; ex_wr1_idx = i1; ex_wr1_data = d1;
      ex_width = w; ex_flags_mask = m; ex_status = s;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      ex_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   initial begin
      int nret;

      do_reset();
      @(negedge clk);
      chk("rst eflags", eflags, 32'h0000_0002);
      chk("rst rf_we", 32'(rf_we), 32'd0);
      chk("rst retire_cnt", 32'(retire_cnt), 32'd0);
      chk("rst ex_ready", 32'(ex_ready), 32'd1);

      // ADD32: CF=1 PF=0 ZF=1 SF=0 OF=1
      set_instr(1, 3'd0, 32'h12345678, 0, 3'd0, 32'd0, 2'b10, 5'b11111, 5'b10101);
      @(posedge clk); #1 ex_valid = 1'b0;
      @(negedge clk);
      chk("add rf_we", 32'(rf_we), 32'd1);
      chk("add rf_idx", 32'(rf_idx), 32'd0);
      chk("add rf_be", 32'(rf_be), 32'hF);
      chk("add rf_data", rf_data, 32'h12345678);
      chk("add retire", 32'(retire), 32'd1);
      chk("add eflags", eflags, 32'h0000_0843);

      // 8-bit high-byte write to AH
      set_instr(1, 3'd4, 32'h000000AB, 0, 3'd0, 32'd0, 2'b00, 5'b00000, 5'b11111);
      @(posedge clk); #1 ex_valid = 1'b0;
      @(negedge clk);
      chk("ah rf_idx", 32'(rf_idx), 32'd0);
      chk("ah rf_data", rf_data, 32'h0000AB00);
      chk("ah rf_be", 32'(rf_be), 32'h2);
      chk("ah eflags", eflags, 32'h0000_0843);

      // XCHG with ex_valid held, followed by a single write
      set_instr(1, 3'd1, 32'hAAAA0000, 1, 3'd2, 32'h0000BBBB, 2'b10, 5'b00000, 5'b00000);
      @(negedge clk);
      chk("xchg1 ex_ready", 32'(ex_ready), 32'd0);
      chk("xchg1 rf_idx", 32'(rf_idx), 32'd1);
      chk("xchg1 rf_data", rf_data, 32'hAAAA0000);
      chk("xchg1 retire", 32'(retire), 32'd0);
      @(negedge clk);
      chk("xchg2 rf_idx", 32'(rf_idx), 32'd2);
      chk("xchg2 rf_data", rf_data, 32'h0000BBBB);
      chk("xchg2 retire", 32'(retire), 32'd1);
      chk("xchg2 ex_ready", 32'(ex_ready), 32'd1);
      set_instr(1, 3'd3, 32'h00000033, 0, 3'd0, 32'd0, 2'b10, 5'b00000, 5'b00000);
      @(negedge clk);
      chk("next rf_idx", 32'(rf_idx), 32'd3);
      chk("next retire", 32'(retire), 32'd1);
      ex_valid = 1'b0;

      // reset while the second XCHG write is pending
      @(negedge clk);
      set_instr(1, 3'd1, 32'h11111111, 1, 3'd2, 32'h22222222, 2'b10, 5'b11111, 5'b11111);
      @(posedge clk); #1;
      rst = 1'b1; ex_valid = 1'b0;
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      chk("rstwr1 rf_we", 32'(rf_we), 32'd0);
      chk("rstwr1 eflags", eflags, 32'h0000_0002);
      chk("rstwr1 retire_cnt", 32'(retire_cnt), 32'd0);
      chk("rstwr1 ex_ready", 32'(ex_ready), 32'd1);

      // 17 back-to-back single writes, counter wraps at 16
      do_reset();
      @(negedge clk);
      set_instr(1, 3'd5, 32'h00001234, 0, 3'd0, 32'd0, 2'b01, 5'b00000, 5'b00000);
      nret = 0;
      for (int i = 0; i < 17; i++) begin
         @(negedge clk);
         nret += int'(retire);
      end
      ex_valid = 1'b0;
      chk("wrap retires", 32'(nret), 32'd17);
      chk("wrap retire_cnt", 32'(retire_cnt), 32'd1);

      // randomized traffic
      for (int i = 0; i < 600; i++) begin
         @(posedge clk); #1;
         if (rst || ex_ready) begin
            set_instr(1'($urandom_range(0, 1)), 3'($urandom), $urandom,
                      1'($urandom_range(0, 1)), 3'($urandom), $urandom,
                      2'($urandom), 5'($urandom), 5'($urandom));
            ex_valid = ($urandom_range(0, 3) != 0);
         end
         rst = ($urandom_range(0, 39) == 0);
      end
      @(posedge clk); #1;
      rst = 1'b0; ex_valid = 1'b0;
      repeat (4) @(posedge clk);
      @(negedge clk);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
